nibble_row_packer: RTL

- Consumer stage placed directly downstream of the 2x2x4 multi-dimensional packing block.
- Accepts one 8-bit row word {b, a} per handshake, where a is the low nibble and b is the high nibble.
- Accumulates ROWS row words into one packed multi-dimensional output word.
- Row 0 sits in the least-significant bits, matching the logic2x4 row layout.
- Emits the packed word over a valid/ready interface, with a flush input for partial words.

---
 rtl/nibble_row_packer_if.sv | 29 ++
 rtl/nibble_row_packer.sv | 105 ++++++++++
 2 files changed

// File: rtl/nibble_row_packer_if.sv
// Handshake bundle between a row source, the nibble row packer and the word sink.
// Carries the row-in channel, the flush strobe and the packed-word-out channel.
// master = environment side (drives rows, flush and out_ready); slave = packer side.
interface nibble_row_packer_if #(
  parameter int NIB_W = 4,
  parameter int ROWS  = 2
);
  localparam int ROW_W = 2 * NIB_W;
  localparam int CNT_W = $clog2(ROWS + 1);

  logic                  in_valid;
  logic                  in_ready;
  logic [ROW_W-1:0]      in_data;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [ROWS*ROW_W-1:0] out_data;
  logic [CNT_W-1:0]      out_count;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_data, out_count
  );
endinterface

// File: rtl/nibble_row_packer.sv
// Packs ROWS row words {b, a} into one word (row 0 in the LSBs); flush closes a partial word.
// Latency: packed word is visible one cycle after the row transfer (or flush) that closes it.
// Backpressure: while a word is held, a new row is accepted only on the cycle the held word drains.
module nibble_row_packer #(
  parameter int NIB_W = 4,
  parameter int ROWS  = 2
) (
  input logic                clk,
  input logic                rst,
  nibble_row_packer_if.slave bus
);
  localparam int ROW_W = 2 * NIB_W;
  localparam int WRD_W = ROWS * ROW_W;
  localparam int IDX_W = $clog2(ROWS);
  localparam int CNT_W = $clog2(ROWS + 1);

  typedef enum logic {FILL, HOLD} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WRD_W-1:0]   acc_q, acc_d;
  logic [WRD_W-1:0]   out_data_q, out_data_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;

  logic               in_xfer;
  logic [WRD_W-1:0]   acc_row;
  logic [CNT_W-1:0]   rows_held;

  // In HOLD the input is only open when the held word leaves in the same cycle.
  assign bus.in_ready  = (state_q == FILL) ? 1'b1 : bus.out_ready;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_data  = out_data_q;
  assign bus.out_count = out_count_q;
  assign in_xfer       = bus.in_valid && bus.in_ready;

  // Next-state: slot write, word closing on last row or flush, and drain of the held word.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;

    // Accumulator as it would look with this cycle's row dropped into slot idx.
    acc_row = acc_q;
    for (int k = 0; k < ROWS; k++) begin
      if (in_xfer && (IDX_W'(k) == idx_q)) begin
        acc_row[k*ROW_W +: ROW_W] = bus.in_data;
      end
    end
    rows_held = CNT_W'(idx_q) + CNT_W'(in_xfer);

    case (state_q)
      FILL: begin
        if (in_xfer && (idx_q == IDX_W'(ROWS - 1))) begin
          // Last slot filled; a coincident flush changes nothing.
          out_data_d  = acc_row;
          out_count_d = CNT_W'(ROWS);
          acc_d       = '0;
          idx_d       = '0;
          state_d     = HOLD;
        end else if (bus.flush && (rows_held != '0)) begin
          // Partial word; absent rows are zero because the accumulator starts cleared.
          out_data_d  = acc_row;
          out_count_d = rows_held;
          acc_d       = '0;
          idx_d       = '0;
          state_d     = HOLD;
        end else if (in_xfer) begin
          acc_d = acc_row;
          idx_d = idx_q + IDX_W'(1);
        end
      end
      HOLD: begin
        // flush is deliberately ignored here; the held word is already closed.
        if (bus.out_ready) begin
          state_d = FILL;
          if (in_xfer) begin
            // idx_q is 0 and acc_q is clear in HOLD, so this lands in slot 0.
            acc_d = acc_row;
            idx_d = IDX_W'(1);
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  // State registers; reset discards partial rows and any held word at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FILL;
      idx_q       <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
    end
  end
endmodule
